dmem_block_responder: RTL and testbench
=======================================

// Module: dmem_block_responder
// PURPOSE
//  Main-memory responder on the data-cache <-> memory block interface: serves whole-block
//  reads (miss fill) and writes (dirty write-back) issued by the data cache controller.
//  Holds 2**ADDR_W blocks of DATA_W bits, with a fixed, parameterised access latency.
//  Drives BUSYWAIT so the cache FSM stalls in its memory-read/write states until done.
// PARAMETERS
//  ADDR_W   6   block address width; depth = 2**ADDR_W blocks (64 x 32b = 256 bytes)
//  DATA_W   32  block width in bits
//  LATENCY  5   clock edges from request acceptance to completion; legal range 1..255
// PORTS
//  CLK        in   1       clock, rising-edge active
//  RESET_N    in   1       asynchronous reset, active-low
//  READ       in   1       block read request, level, held by cache until BUSYWAIT low
//  WRITE      in   1       block write request, level, held by cache until BUSYWAIT low
//  ADDRESS    in   ADDR_W  block address {tag,index}
//  WRITEDATA  in   DATA_W  block to store on WRITE
//  READDATA   out  DATA_W  block returned on READ; registered
//  BUSYWAIT   out  1       high while a request is pending/in progress
// BEHAVIOUR
//  Reset (RESET_N low, async): state=IDLE, counter=0, READDATA=0, BUSYWAIT=0, array zeroed.
//   Reset mid-access aborts it: no array update, READDATA=0, BUSYWAIT low immediately.
//  States: IDLE, ACCESS, DONE.
//  IDLE: BUSYWAIT = READ ^ WRITE (combinational, same cycle as request, so cache sees
//   busy at its first sampling edge). On rising edge with exactly one of READ/WRITE high:
//   latch op, ADDRESS, WRITEDATA; counter=LATENCY-1; -> ACCESS.
//  ACCESS: BUSYWAIT=1. Each edge: counter==0 -> perform op, -> DONE; else counter-1.
//   Read: READDATA <= array[addr]. Write: array[addr] <= latched WRITEDATA.
//   DONE is entered exactly LATENCY edges after the acceptance edge.
//  DONE: BUSYWAIT=0 for one cycle; next edge -> IDLE unconditionally (no new acceptance in
//   DONE; a request still high re-raises BUSYWAIT in IDLE and is accepted there).
//  Inputs changing/dropping during ACCESS are ignored; latched values are used, no abort.
//  READ & WRITE both high in IDLE: illegal, not accepted, BUSYWAIT=0, no state change.
//  READDATA holds last read block until the next read completes; writes do not alter it.
//  Read-after-write to the same address returns the newly written block.
//  Address range full 0..2**ADDR_W-1; no wrap or aliasing.
// CONFIGURATION
//  DMEM_ACCESS_CNT_EN defined: adds outputs RD_COUNT[15:0], WR_COUNT[15:0]; each increments
//   on the edge entering DONE for its op, saturates at 16'hFFFF, cleared by RESET_N.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  WRITE addr 6'd5 data 32'hDEADBEEF -> BUSYWAIT high same cycle, low in DONE at edge +5;
//   then READ addr 5 -> READDATA=32'hDEADBEEF when BUSYWAIT falls.
//  LATENCY=1 and LATENCY=5 builds: count edges acceptance->BUSYWAIT low = 1 and 5 exactly.
//  Write 32'h00000001 to addr 0 and 32'hFFFFFFFF to addr 63, read both back -> no aliasing.
//  READ and WRITE both high 10 cycles -> BUSYWAIT=0, state IDLE, array unchanged.
//  RESET_N low at edge +2 of a WRITE to addr 9 -> BUSYWAIT=0 async; read addr 9 -> 0.
//  With DMEM_ACCESS_CNT_EN: 3 writes + 2 reads -> WR_COUNT=3, RD_COUNT=2; preset near
//   saturation via 65540 reads -> RD_COUNT stays 16'hFFFF.

Source files
------------

// File: rtl/dmem_block_responder.sv
// Block-granular main-memory model for the data cache: fixed-latency whole-block reads/writes.
// Optional access counters (RD_COUNT/WR_COUNT) are compiled in when DMEM_ACCESS_CNT_EN is defined.
module dmem_block_responder #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [15:0]       RD_COUNT,
    output logic [15:0]       WR_COUNT,
`endif
    output logic              BUSYWAIT
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [7:0]  CntInit = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] mem_q [Depth];

    logic accept;
    logic complete;
    logic busy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Combinational so the cache sees busy at its very first sampling edge.
                busy = READ ^ WRITE;
                if (READ ^ WRITE) begin
                    accept  = 1'b1;
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                busy = 1'b1;
                if (cnt_q == 8'd0) begin
                    complete = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_write_q <= WRITE;
                addr_q     <= ADDRESS;
                wdata_q    <= WRITEDATA;
            end
            if (complete && !op_write_q) begin
                readdata_q <= mem_q[addr_q];
            end
        end
    end

    // Storage is cleared by reset, so an aborted write can never leave partial state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && op_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count_q, wr_count_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else if (complete) begin
            if (op_write_q && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (!op_write_q && rd_count_q != 16'hFFFF) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign RD_COUNT = rd_count_q;
    assign WR_COUNT = wr_count_q;
`endif

    assign READDATA = readdata_q;
    assign BUSYWAIT = busy;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Randomized self-checking bench for dmem_block_responder against an array-based memory model.
// Runs a LATENCY=5 instance for the bulk of stimulus and a LATENCY=1 instance for edge timing.
module tb_dmem_block_responder;

    localparam int unsigned Lat = 5;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [5:0]  ADDRESS = '0;
    logic [31:0] WRITEDATA = '0;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    logic        rd1 = 1'b0;
    logic        wr1 = 1'b0;
    logic [5:0]  addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [31:0] rdata1;
    logic        busy1;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count, wr_count, rd_count1, wr_count1;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rd;
    int          ref_rd_cnt;
    int          ref_wr_cnt;

    always #5 CLK = ~CLK;

    dmem_block_responder #(
        .ADDR_W (6),
        .DATA_W (32),
        .LATENCY(Lat)
    ) u_dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
`ifdef DMEM_ACCESS_CNT_EN
        .RD_COUNT (rd_count),
        .WR_COUNT (wr_count),
`endif
        .BUSYWAIT (BUSYWAIT)
    );

    dmem_block_responder #(
        .ADDR_W (6),
        .DATA_W (32),
        .LATENCY(1)
    ) u_dut_lat1 (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .READ     (rd1),
        .WRITE    (wr1),
        .ADDRESS  (addr1),
        .WRITEDATA(wdata1),
        .READDATA (rdata1),
`ifdef DMEM_ACCESS_CNT_EN
        .RD_COUNT (rd_count1),
        .WR_COUNT (wr_count1),
`endif
        .BUSYWAIT (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        ref_rd     = '0;
        ref_rd_cnt = 0;
        ref_wr_cnt = 0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that re-enters idle.
    task automatic mem_op(input bit is_wr, input logic [5:0] addr, input logic [31:0] data);
        int edges;
        READ      = !is_wr;
        WRITE     = is_wr;
        ADDRESS   = addr;
        WRITEDATA = data;
        #1 check_eq("busy_on_request", 32'(BUSYWAIT), 32'd1);
        @(posedge CLK);
        #1;
        // Scramble the bus mid-access; the latched request must be used.
        ADDRESS   = 6'($urandom);
        WRITEDATA = $urandom;
        edges = 0;
        while (BUSYWAIT === 1'b1 && edges < 300) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check_eq(is_wr ? "write_latency" : "read_latency", 32'(edges), 32'(Lat));
        if (is_wr) begin
            ref_mem[addr] = data;
            ref_wr_cnt++;
        end else begin
            ref_rd = ref_mem[addr];
            ref_rd_cnt++;
        end
        check_eq(is_wr ? "readdata_after_write" : "readdata_after_read", READDATA, ref_rd);
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK);
        #1 check_eq("busy_idle_after_done", 32'(BUSYWAIT), 32'd0);
    endtask

    task automatic lat1_op(input bit is_wr, input logic [5:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd);
        int edges;
        rd1    = !is_wr;
        wr1    = is_wr;
        addr1  = addr;
        wdata1 = data;
        @(posedge CLK);
        #1;
        edges = 0;
        while (busy1 === 1'b1 && edges < 300) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check_eq("lat1_edges", 32'(edges), 32'd1);
        check_eq("lat1_readdata", rdata1, exp_rd);
        rd1 = 1'b0;
        wr1 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] keep_rd;

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("reset_readdata", READDATA, 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Directed: write then read back.
        mem_op(1'b1, 6'd5, 32'hDEADBEEF);
        mem_op(1'b0, 6'd5, 32'h0);
        check_eq("deadbeef_readback", READDATA, 32'hDEADBEEF);

        // Extreme addresses must not alias.
        mem_op(1'b1, 6'd0, 32'h00000001);
        mem_op(1'b1, 6'd63, 32'hFFFFFFFF);
        mem_op(1'b0, 6'd0, 32'h0);
        mem_op(1'b0, 6'd63, 32'h0);

        // LATENCY=1 instance.
        lat1_op(1'b1, 6'd17, 32'hA5A5_0F0F, 32'h0);
        lat1_op(1'b0, 6'd17, 32'h0, 32'hA5A5_0F0F);

        // Illegal simultaneous READ/WRITE: never accepted.
        READ      = 1'b1;
        WRITE     = 1'b1;
        ADDRESS   = 6'd5;
        WRITEDATA = 32'h1234_5678;
        keep_rd   = READDATA;
        for (int i = 0; i < 10; i++) begin
            #1 check_eq("both_high_busywait", 32'(BUSYWAIT), 32'd0);
            @(posedge CLK);
        end
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        check_eq("both_high_readdata_held", READDATA, keep_rd);
        mem_op(1'b0, 6'd5, 32'h0);

        // Randomized traffic, biased towards a small address window for reuse.
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            d = $urandom;
            mem_op(1'($urandom_range(0, 1)), a, d);
        end

`ifdef DMEM_ACCESS_CNT_EN
        check_eq("rd_count", 32'(rd_count), 32'(ref_rd_cnt));
        check_eq("wr_count", 32'(wr_count), 32'(ref_wr_cnt));
`endif

        // Reset two edges into a write: aborted, everything cleared.
        WRITE     = 1'b1;
        ADDRESS   = 6'd9;
        WRITEDATA = 32'hCAFE_F00D;
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        WRITE   = 1'b0;
        #1;
        check_eq("reset_abort_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("reset_abort_readdata", READDATA, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        mem_op(1'b0, 6'd9, 32'h0);
        mem_op(1'b0, 6'd63, 32'h0);
        mem_op(1'b0, 6'd5, 32'h0);

`ifdef DMEM_ACCESS_CNT_EN
        check_eq("rd_count_after_reset", 32'(rd_count), 32'(ref_rd_cnt));
        check_eq("wr_count_after_reset", 32'(wr_count), 32'(ref_wr_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
